// File: rtl/xadc_pkg.sv
// Shared constants and types for the XADC aux-channel scan logic.
// Holds the scan FSM state encoding, channel geometry, DRP addressing and result width.
package xadc_pkg;

    localparam int N_AUX      = 4;
    localparam int CH_W       = 2;
    localparam int MUX_W      = 4;
    localparam int RES_W      = 12;
    localparam int DRP_ADDR_W = 7;
    localparam int DRP_DATA_W = 16;

    localparam logic [DRP_ADDR_W-1:0] DRP_ADDR_VPVN = 7'h03;

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETTLE,
        S_CONVST,
        S_WAIT_EOC,
        S_DRP_RD,
        S_WAIT_DRDY,
        S_STORE,
        S_NEXT
    } scan_state_t;

    // The external mux only decodes the low bits; the upper select lines stay low.
    function automatic logic [MUX_W-1:0] chan_muxaddr(input logic [CH_W-1:0] ch);
        return {2'b00, ch};
    endfunction

endpackage

// File: rtl/xadc_aux_scan_ctrl_if.sv
// Bundle between the scan controller (master) and the XADC primitive / DRP port (slave).
// No flow control beyond the XADC's own eoc and drp_drdy strobes.
interface xadc_aux_scan_if;

    logic [xadc_pkg::MUX_W-1:0]      XADC_MUXADDR;
    logic                            convst;
    logic                            eoc;
    logic                            drp_den;
    logic [xadc_pkg::DRP_ADDR_W-1:0] drp_daddr;
    logic [xadc_pkg::DRP_DATA_W-1:0] drp_do;
    logic                            drp_drdy;

    modport master (
        output XADC_MUXADDR,
        output convst,
        output drp_den,
        output drp_daddr,
        input  eoc,
        input  drp_do,
        input  drp_drdy
    );

    modport slave (
        input  XADC_MUXADDR,
        input  convst,
        input  drp_den,
        input  drp_daddr,
        output eoc,
        output drp_do,
        output drp_drdy
    );

endinterface

// File: rtl/rr_next_chan.sv
// Round-robin pick of the next enabled channel strictly after cur_i (wrapping), cur_i itself last.
// Purely combinational, zero latency; none_o flags an empty mask.
module rr_next_chan
    import xadc_pkg::*;
(
    input  logic [N_AUX-1:0] mask_i,
    input  logic [CH_W-1:0]  cur_i,
    output logic [CH_W-1:0]  nxt_o,
    output logic             none_o
);

    // Walk from the farthest candidate to the nearest so the nearest enabled one wins.
    always_comb begin
        nxt_o  = cur_i;
        none_o = 1'b1;
        for (int k = N_AUX; k >= 1; k--) begin
            if (mask_i[cur_i + CH_W'(k)]) begin
                nxt_o  = cur_i + CH_W'(k);
                none_o = 1'b0;
            end
        end
    end

endmodule

// File: rtl/xadc_aux_scan_ctrl.sv
// Round-robin scanner for the four external-mux aux channels: mux, settle, convst, eoc, DRP read, store.
// Per channel SETTLE_CYCLES+eoc wait+drdy wait+3 clocks; stalls on eoc/drdy, aborting after EOC_TIMEOUT.
module xadc_aux_scan_ctrl
    import xadc_pkg::*;
#(
    parameter int unsigned            SETTLE_CYCLES   = 256,
    parameter int unsigned            EOC_TIMEOUT     = 4096,
    parameter logic [DRP_ADDR_W-1:0]  DRP_RESULT_ADDR = DRP_ADDR_VPVN
) (
    input  logic                 S_AXI_ACLK,
    input  logic                 S_AXI_ARESETN,
    input  logic                 scan_en,
    input  logic [N_AUX-1:0]     chan_mask,
    input  logic                 err_clr,
    xadc_aux_scan_if.master      xadc,
    output logic [RES_W-1:0]     aux0,
    output logic [RES_W-1:0]     aux1,
    output logic [RES_W-1:0]     aux2,
    output logic [RES_W-1:0]     aux3,
    output logic [N_AUX-1:0]     sample_valid,
    output logic                 busy,
    output logic                 timeout_err
);

    localparam int unsigned CNT_MAX = (SETTLE_CYCLES > EOC_TIMEOUT) ? SETTLE_CYCLES : EOC_TIMEOUT;
    localparam int          CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

    localparam logic [CNT_W-1:0] SETTLE_LAST  = CNT_W'(SETTLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(EOC_TIMEOUT - 1);

    scan_state_t             state_q;
    logic [CH_W-1:0]         ptr_q;
    logic [MUX_W-1:0]        mux_q;
    logic [CNT_W-1:0]        cnt_q;
    logic                    convst_q;
    logic                    den_q;
    logic [DRP_ADDR_W-1:0]   daddr_q;
    logic [N_AUX-1:0]        sv_q;
    logic                    busy_q;
    logic                    terr_q;
    logic [RES_W-1:0]        aux_q [N_AUX];

    logic [CH_W-1:0]         nxt_ch;
    logic                    nxt_none;

    rr_next_chan u_rr_next_chan (
        .mask_i (chan_mask),
        .cur_i  (ptr_q),
        .nxt_o  (nxt_ch),
        .none_o (nxt_none)
    );

    // The low nibble of the DRP word carries no result bits.
    logic unused_drp_lsb;
    assign unused_drp_lsb = ^xadc.drp_do[3:0];

    always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
        if (!S_AXI_ARESETN) begin
            state_q  <= S_IDLE;
            ptr_q    <= CH_W'(N_AUX - 1);
            mux_q    <= '0;
            cnt_q    <= '0;
            convst_q <= 1'b0;
            den_q    <= 1'b0;
            daddr_q  <= '0;
            sv_q     <= '0;
            busy_q   <= 1'b0;
            terr_q   <= 1'b0;
            for (int i = 0; i < N_AUX; i++) begin
                aux_q[i] <= '0;
            end
        end else begin
            // A timeout set later in this block overrides a same-cycle clear.
            if (err_clr) begin
                terr_q <= 1'b0;
            end

            unique case (state_q)
                S_IDLE, S_NEXT: begin
                    if (scan_en && !nxt_none) begin
                        ptr_q   <= nxt_ch;
                        mux_q   <= chan_muxaddr(nxt_ch);
                        cnt_q   <= '0;
                        busy_q  <= 1'b1;
                        state_q <= S_SETTLE;
                    end else begin
                        busy_q  <= 1'b0;
                        state_q <= S_IDLE;
                    end
                end

                S_SETTLE: begin
                    if (cnt_q == SETTLE_LAST) begin
                        convst_q <= 1'b1;
                        state_q  <= S_CONVST;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end

                S_CONVST: begin
                    convst_q <= 1'b0;
                    cnt_q    <= '0;
                    state_q  <= S_WAIT_EOC;
                end

                S_WAIT_EOC: begin
                    if (xadc.eoc) begin
                        den_q   <= 1'b1;
                        daddr_q <= DRP_RESULT_ADDR;
                        state_q <= S_DRP_RD;
                    end else if (cnt_q == TIMEOUT_LAST) begin
                        terr_q  <= 1'b1;
                        state_q <= S_NEXT;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end

                S_DRP_RD: begin
                    den_q   <= 1'b0;
                    cnt_q   <= '0;
                    state_q <= S_WAIT_DRDY;
                end

                S_WAIT_DRDY: begin
                    if (xadc.drp_drdy) begin
                        aux_q[ptr_q] <= xadc.drp_do[DRP_DATA_W-1:DRP_DATA_W-RES_W];
                        sv_q         <= N_AUX'(1) << ptr_q;
                        state_q      <= S_STORE;
                    end else if (cnt_q == TIMEOUT_LAST) begin
                        terr_q  <= 1'b1;
                        state_q <= S_NEXT;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end

                S_STORE: begin
                    sv_q    <= '0;
                    state_q <= S_NEXT;
                end

                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign xadc.XADC_MUXADDR = mux_q;
    assign xadc.convst       = convst_q;
    assign xadc.drp_den      = den_q;
    assign xadc.drp_daddr    = daddr_q;

    assign aux0         = aux_q[0];
    assign aux1         = aux_q[1];
    assign aux2         = aux_q[2];
    assign aux3         = aux_q[3];
    assign sample_valid = sv_q;
    assign busy         = busy_q;
    assign timeout_err  = terr_q;

endmodule

// File: tb/tb_xadc_aux_scan_ctrl.sv
// Directed bench for xadc_aux_scan_ctrl with a reactive XADC/DRP model.
// Table of round-robin visits plus hand sequences for settle timing, scan stop, timeout, empty mask and reset.
module tb_xadc_aux_scan_ctrl;
    import xadc_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic        scan_en;
    logic [3:0]  chan_mask;
    logic        err_clr;
    logic [11:0] aux0, aux1, aux2, aux3;
    logic [3:0]  sample_valid;
    logic        busy;
    logic        timeout_err;

    xadc_aux_scan_if xif();

    xadc_aux_scan_ctrl dut (
        .S_AXI_ACLK    (clk),
        .S_AXI_ARESETN (rst_n),
        .scan_en       (scan_en),
        .chan_mask     (chan_mask),
        .err_clr       (err_clr),
        .xadc          (xif.master),
        .aux0          (aux0),
        .aux1          (aux1),
        .aux2          (aux2),
        .aux3          (aux3),
        .sample_valid  (sample_valid),
        .busy          (busy),
        .timeout_err   (timeout_err)
    );

    int n_checks = 0;
    int n_err    = 0;

    // XADC model knobs: result tag in drp_do[11:4], and an optional channel whose eoc is withheld.
    logic [7:0] tag       = 8'hAB;
    logic       eoc_block = 1'b0;
    logic [1:0] eoc_ch    = 2'd1;

    // eoc arrives 20 clocks after convst is seen.
    initial begin
        logic [1:0] ch;
        xif.eoc = 1'b0;
        forever begin
            @(negedge clk);
            if (xif.convst) begin
                ch = xif.XADC_MUXADDR[1:0];
                repeat (19) @(negedge clk);
                if (!(eoc_block && ch == eoc_ch)) begin
                    xif.eoc = 1'b1;
                    @(negedge clk);
                    xif.eoc = 1'b0;
                end
            end
        end
    end

    // drp_drdy with {channel, tag, 4'h0} arrives 3 clocks after den.
    initial begin
        logic [1:0] ch;
        xif.drp_drdy = 1'b0;
        xif.drp_do   = '0;
        forever begin
            @(negedge clk);
            if (xif.drp_den) begin
                ch = xif.XADC_MUXADDR[1:0];
                repeat (2) @(negedge clk);
                xif.drp_do   = {2'b00, ch, tag, 4'h0};
                xif.drp_drdy = 1'b1;
                @(negedge clk);
                xif.drp_drdy = 1'b0;
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
        end
    endtask

    task automatic expire(input string name);
        n_checks++;
        n_err++;
        $display("FAIL %s: wait bound expired", name);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_sv(input string name, output logic ok);
        ok = 1'b0;
        for (int n = 0; n < 6000; n++) begin
            tick();
            if (sample_valid != 4'b0) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) expire(name);
    endtask

    function automatic logic [11:0] aux_of(input logic [1:0] ch);
        case (ch)
            2'd0:    return aux0;
            2'd1:    return aux1;
            2'd2:    return aux2;
            default: return aux3;
        endcase
    endfunction

    typedef struct {
        logic [3:0]  mask;
        logic [3:0]  exp_mux;
        logic [3:0]  exp_sv;
        logic [11:0] exp_aux;
    } vec_t;

    vec_t vec [12];

    initial begin
        logic ok;
        int   n;
        int   n_convst;
        int   n_sv;
        int   n_busy;

        vec[0]  = '{4'b1111, 4'd0, 4'b0001, 12'h0AB};
        vec[1]  = '{4'b1111, 4'd1, 4'b0010, 12'h1AB};
        vec[2]  = '{4'b1111, 4'd2, 4'b0100, 12'h2AB};
        vec[3]  = '{4'b1111, 4'd3, 4'b1000, 12'h3AB};
        vec[4]  = '{4'b1111, 4'd0, 4'b0001, 12'h0AB};
        vec[5]  = '{4'b0101, 4'd2, 4'b0100, 12'h2AB};
        vec[6]  = '{4'b0101, 4'd0, 4'b0001, 12'h0AB};
        vec[7]  = '{4'b1000, 4'd3, 4'b1000, 12'h3AB};
        vec[8]  = '{4'b1000, 4'd3, 4'b1000, 12'h3AB};
        vec[9]  = '{4'b0011, 4'd0, 4'b0001, 12'h0AB};
        vec[10] = '{4'b0010, 4'd1, 4'b0010, 12'h1AB};
        vec[11] = '{4'b1001, 4'd3, 4'b1000, 12'h3AB};

        rst_n     = 1'b0;
        scan_en   = 1'b0;
        chan_mask = 4'b0;
        err_clr   = 1'b0;
        repeat (3) tick();

        check("rst_mux",    xif.XADC_MUXADDR, 0);
        check("rst_convst", xif.convst, 0);
        check("rst_den",    xif.drp_den, 0);
        check("rst_aux",    {aux0, aux1, aux2, aux3}, 0);
        check("rst_sv",     sample_valid, 0);
        check("rst_busy",   busy, 0);
        check("rst_terr",   timeout_err, 0);

        rst_n = 1'b1;
        repeat (2) tick();
        check("idle_busy", busy, 0);

        // Settle length, convst width, den/daddr timing on the first channel.
        chan_mask = vec[0].mask;
        scan_en   = 1'b1;
        tick();
        check("first_mux",  xif.XADC_MUXADDR, 0);
        check("first_busy", busy, 1);
        n = 0;
        while (!xif.convst && n < 400) begin
            tick();
            n++;
        end
        check("settle_cycles", n, 256);
        tick();
        check("convst_width", xif.convst, 0);
        n = 0;
        while (!xif.eoc && n < 100) begin
            tick();
            n++;
        end
        if (n >= 100) expire("eoc_wait");
        check("den_after_eoc", xif.drp_den, 1);
        check("daddr",         xif.drp_daddr, 7'h03);
        tick();
        check("den_width",  xif.drp_den, 0);
        check("daddr_hold", xif.drp_daddr, 7'h03);

        // Round-robin visits; each record's mask is in place before that selection.
        for (int i = 0; i < 12; i++) begin
            chan_mask = vec[i].mask;
            wait_sv($sformatf("vec%0d_wait", i), ok);
            if (ok) begin
                check($sformatf("vec%0d_sv", i),   sample_valid, vec[i].exp_sv);
                check($sformatf("vec%0d_mux", i),  xif.XADC_MUXADDR, vec[i].exp_mux);
                check($sformatf("vec%0d_aux", i),  aux_of(vec[i].exp_mux[1:0]), vec[i].exp_aux);
                check($sformatf("vec%0d_busy", i), busy, 1);
            end
        end

        // scan_en drops while channel 2 settles: channel 2 still completes, then idle.
        chan_mask = 4'b0101;
        tag       = 8'hCD;
        wait_sv("stop_ch0_wait", ok);
        check("stop_ch0_sv",  sample_valid, 4'b0001);
        check("stop_ch0_aux", aux0, 12'h0CD);
        n = 0;
        while (xif.XADC_MUXADDR != 4'd2 && n < 100) begin
            tick();
            n++;
        end
        if (n >= 100) expire("stop_mux2_wait");
        scan_en = 1'b0;
        wait_sv("stop_ch2_wait", ok);
        check("stop_ch2_sv",  sample_valid, 4'b0100);
        check("stop_ch2_aux", aux2, 12'h2CD);
        repeat (2) tick();
        check("stop_busy", busy, 0);
        n_convst = 0;
        n_sv     = 0;
        n_busy   = 0;
        for (int i = 0; i < 300; i++) begin
            tick();
            n_convst += int'(xif.convst);
            n_sv     += int'(sample_valid != 4'b0);
            n_busy   += int'(busy);
        end
        check("stop_idle_convst", n_convst, 0);
        check("stop_idle_sv",     n_sv, 0);
        check("stop_idle_busy",   n_busy, 0);
        check("stop_aux1_kept",   aux1, 12'h1AB);
        check("stop_aux3_kept",   aux3, 12'h3AB);

        // eoc withheld on channel 1: abort after the full wait, aux1 untouched, scan moves to 2.
        tag       = 8'hEE;
        eoc_block = 1'b1;
        chan_mask = 4'b0110;
        scan_en   = 1'b1;
        n = 0;
        while (!xif.convst && n < 400) begin
            tick();
            n++;
        end
        if (n >= 400) expire("to_convst_wait");
        check("to_mux", xif.XADC_MUXADDR, 1);
        n = 0;
        while (!timeout_err && n < 5000) begin
            tick();
            n++;
        end
        // One CONVST cycle plus EOC_TIMEOUT cycles in WAIT_EOC.
        check("to_latency", n, 4097);
        check("to_aux1",    aux1, 12'h1AB);
        wait_sv("to_ch2_wait", ok);
        check("to_ch2_sv",     sample_valid, 4'b0100);
        check("to_ch2_aux",    aux2, 12'h2EE);
        check("to_sticky",     timeout_err, 1);
        check("to_aux1_again", aux1, 12'h1AB);
        err_clr = 1'b1;
        scan_en = 1'b0;
        tick();
        err_clr = 1'b0;
        check("to_clr", timeout_err, 0);
        tick();
        check("to_idle_busy", busy, 0);
        eoc_block = 1'b0;

        // Empty mask keeps the controller idle; a single-bit mask repeats that channel.
        chan_mask = 4'b0000;
        scan_en   = 1'b1;
        n_convst  = 0;
        n_busy    = 0;
        for (int i = 0; i < 300; i++) begin
            tick();
            n_convst += int'(xif.convst);
            n_busy   += int'(busy);
        end
        check("empty_convst", n_convst, 0);
        check("empty_busy",   n_busy, 0);
        chan_mask = 4'b1000;
        tag       = 8'h33;
        for (int i = 0; i < 2; i++) begin
            wait_sv($sformatf("solo%0d_wait", i), ok);
            check($sformatf("solo%0d_sv", i),  sample_valid, 4'b1000);
            check($sformatf("solo%0d_mux", i), xif.XADC_MUXADDR, 3);
            check($sformatf("solo%0d_aux", i), aux3, 12'h333);
        end

        // Reset during WAIT_DRDY clears everything at once; scan then restarts at channel 0.
        chan_mask = 4'b1111;
        n = 0;
        while (!xif.drp_den && n < 600) begin
            tick();
            n++;
        end
        if (n >= 600) expire("rst_den_wait");
        tick();
        rst_n = 1'b0;
        #1;
        check("mid_rst_mux",    xif.XADC_MUXADDR, 0);
        check("mid_rst_convst", xif.convst, 0);
        check("mid_rst_den",    xif.drp_den, 0);
        check("mid_rst_daddr",  xif.drp_daddr, 0);
        check("mid_rst_aux",    {aux0, aux1, aux2, aux3}, 0);
        check("mid_rst_sv",     sample_valid, 0);
        check("mid_rst_busy",   busy, 0);
        check("mid_rst_terr",   timeout_err, 0);
        n_convst = 0;
        for (int i = 0; i < 4; i++) begin
            tick();
            n_convst += int'(xif.convst) + int'(xif.drp_den);
        end
        check("mid_rst_no_glitch", n_convst, 0);
        tag   = 8'h77;
        rst_n = 1'b1;
        wait_sv("restart_wait", ok);
        check("restart_sv",  sample_valid, 4'b0001);
        check("restart_aux", aux0, 12'h077);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
